register_file_2r1w: RTL and testbench

- Parametrised successor to the 16x8 single-port register unit.
- Configurable width and depth, one write port, two independent registered read ports for dual ALU operand fetch, and write-first bypass.
- Optional hard-wired zero register.
- A sequential background clear engine that zeroes the array one entry per cycle without asserting reset.

---
 rtl/register_file_2r1w.sv | 97 +++++++++
 tb/tb_register_file_2r1w.sv | 271 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/register_file_2r1w.sv
// rtl/register_file_2r1w.sv - parametrised 2-read/1-write register file with bypass and background clear
module register_file_2r1w #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int ZERO_REG   = 0
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  load,
    input  logic [ADDR_WIDTH-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] data_in,
    input  logic                  ren_a,
    input  logic [ADDR_WIDTH-1:0] raddr_a,
    output logic [DATA_WIDTH-1:0] data_out_a,
    input  logic                  ren_b,
    input  logic [ADDR_WIDTH-1:0] raddr_b,
    output logic [DATA_WIDTH-1:0] data_out_b,
    input  logic                  clear,
    output logic                  busy
);
    localparam int DEPTH = 1 << ADDR_WIDTH;

    typedef enum logic {IDLE, SWEEP} state_t;

    state_t                state;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  write_ok;
    logic [DATA_WIDTH-1:0] rd_a;
    logic [DATA_WIDTH-1:0] rd_b;

    assign write_ok = load && !busy && !((ZERO_REG != 0) && (waddr == '0));

    // Entry under the sweep pointer is zeroed this edge, so reads of it bypass to 0.
    always_comb begin
        rd_a = mem[raddr_a];
        if ((ZERO_REG != 0) && (raddr_a == '0))
            rd_a = '0;
        else if (busy && (raddr_a == ptr))
            rd_a = '0;
        else if (write_ok && (waddr == raddr_a))
            rd_a = data_in;
    end

    always_comb begin
        rd_b = mem[raddr_b];
        if ((ZERO_REG != 0) && (raddr_b == '0))
            rd_b = '0;
        else if (busy && (raddr_b == ptr))
            rd_b = '0;
        else if (write_ok && (waddr == raddr_b))
            rd_b = data_in;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            mem        <= '{default: '0};
            data_out_a <= '0;
            data_out_b <= '0;
            busy       <= 1'b0;
            ptr        <= '0;
            state      <= IDLE;
        end else begin
            if (ren_a)
                data_out_a <= rd_a;
            if (ren_b)
                data_out_b <= rd_b;
            if (write_ok)
                mem[waddr] <= data_in;

            case (state)
                IDLE: begin
                    if (clear) begin
                        state <= SWEEP;
                        ptr   <= '0;
                        busy  <= 1'b1;
                    end
                end
                SWEEP: begin
                    mem[ptr] <= '0;
                    if (ptr == ADDR_WIDTH'(DEPTH - 1)) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        ptr   <= '0;
                    end else begin
                        ptr <= ptr + 1'b1;
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                    ptr   <= '0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_register_file_2r1w.sv
// tb/tb_register_file_2r1w.sv - directed self-checking bench for register_file_2r1w
module tb_register_file_2r1w;
    logic       clock;
    logic       reset;
    logic       load;
    logic [3:0] waddr;
    logic [7:0] data_in;
    logic       ren_a;
    logic [3:0] raddr_a;
    logic [7:0] data_out_a;
    logic       ren_b;
    logic [3:0] raddr_b;
    logic [7:0] data_out_b;
    logic       clear;
    logic       busy;
    logic [7:0] z_data_out_a;
    logic [7:0] z_data_out_b;
    logic       z_busy;

    int checks = 0;
    int errors = 0;

    register_file_2r1w #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ZERO_REG(0)) dut (
        .clock(clock), .reset(reset), .load(load), .waddr(waddr), .data_in(data_in),
        .ren_a(ren_a), .raddr_a(raddr_a), .data_out_a(data_out_a),
        .ren_b(ren_b), .raddr_b(raddr_b), .data_out_b(data_out_b),
        .clear(clear), .busy(busy)
    );

    register_file_2r1w #(.DATA_WIDTH(8), .ADDR_WIDTH(4), .ZERO_REG(1)) dut_z (
        .clock(clock), .reset(reset), .load(load), .waddr(waddr), .data_in(data_in),
        .ren_a(ren_a), .raddr_a(raddr_a), .data_out_a(z_data_out_a),
        .ren_b(ren_b), .raddr_b(raddr_b), .data_out_b(z_data_out_b),
        .clear(clear), .busy(z_busy)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        load = 1'b0; waddr = '0; data_in = '0;
        ren_a = 1'b0; raddr_a = '0; ren_b = 1'b0; raddr_b = '0;
        clear = 1'b0;
    endtask

    task automatic write(input logic [3:0] a, input logic [7:0] d);
        load = 1'b1; waddr = a; data_in = d;
        tick();
        load = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        write(4'd15, 8'hAA);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0) begin
            errors++; $display("FAIL reset_busy: got %b want 0", busy);
        end
        ren_a = 1'b1; raddr_a = 4'd0; ren_b = 1'b1; raddr_b = 4'd15;
        tick();
        checks++;
        if (data_out_a !== 8'h00) begin
            errors++; $display("FAIL reset_read_a: got %h want 00", data_out_a);
        end
        checks++;
        if (data_out_b !== 8'h00) begin
            errors++; $display("FAIL reset_read_b15: got %h want 00", data_out_b);
        end
        idle_inputs();
    endtask

    task automatic test_write_read();
        write(4'd3, 8'h5A);
        ren_a = 1'b1; raddr_a = 4'd3;
        tick();
        checks++;
        if (data_out_a !== 8'h5A) begin
            errors++; $display("FAIL read_a3: got %h want 5a", data_out_a);
        end
        ren_a = 1'b0; raddr_a = 4'd5;
        tick();
        checks++;
        if (data_out_a !== 8'h5A) begin
            errors++; $display("FAIL hold_a: got %h want 5a", data_out_a);
        end
        idle_inputs();
    endtask

    task automatic test_bypass();
        load = 1'b1; waddr = 4'd7; data_in = 8'hC3;
        ren_a = 1'b1; raddr_a = 4'd7; ren_b = 1'b1; raddr_b = 4'd7;
        tick();
        load = 1'b0;
        checks++;
        if (data_out_a !== 8'hC3) begin
            errors++; $display("FAIL bypass_a: got %h want c3", data_out_a);
        end
        checks++;
        if (data_out_b !== 8'hC3) begin
            errors++; $display("FAIL bypass_b: got %h want c3", data_out_b);
        end
        raddr_a = 4'd3; raddr_b = 4'd7;
        tick();
        checks++;
        if (data_out_a !== 8'h5A) begin
            errors++; $display("FAIL indep_a3: got %h want 5a", data_out_a);
        end
        checks++;
        if (data_out_b !== 8'hC3) begin
            errors++; $display("FAIL stored_b7: got %h want c3", data_out_b);
        end
        idle_inputs();
    endtask

    task automatic test_zero_reg();
        load = 1'b1; waddr = 4'd0; data_in = 8'hFF;
        ren_a = 1'b1; raddr_a = 4'd0;
        tick();
        load = 1'b0;
        checks++;
        if (z_data_out_a !== 8'h00) begin
            errors++; $display("FAIL zero_bypass_z: got %h want 00", z_data_out_a);
        end
        checks++;
        if (data_out_a !== 8'hFF) begin
            errors++; $display("FAIL nonzero_bypass_r0: got %h want ff", data_out_a);
        end
        tick();
        checks++;
        if (z_data_out_a !== 8'h00) begin
            errors++; $display("FAIL zero_read_r0: got %h want 00", z_data_out_a);
        end
        ren_a = 1'b0;
        write(4'd1, 8'hFF);
        ren_b = 1'b1; raddr_b = 4'd1;
        tick();
        checks++;
        if (z_data_out_b !== 8'hFF) begin
            errors++; $display("FAIL zero_read_r1: got %h want ff", z_data_out_b);
        end
        checks++;
        if (z_busy !== 1'b0) begin
            errors++; $display("FAIL zero_busy: got %b want 0", z_busy);
        end
        idle_inputs();
    endtask

    task automatic test_clear();
        int busy_cycles;
        for (int i = 0; i < 16; i++)
            write(4'(i), 8'(8'h10 + i));
        clear = 1'b1;
        tick();
        clear = 1'b0;
        busy_cycles = 0;
        if (busy === 1'b1) busy_cycles++;
        tick();
        if (busy === 1'b1) busy_cycles++;
        // second busy cycle: pointer at 1; read 15, drop a write, re-pulse clear
        ren_a = 1'b1; raddr_a = 4'd15;
        load = 1'b1; waddr = 4'd15; data_in = 8'hEE;
        clear = 1'b1;
        tick();
        if (busy === 1'b1) busy_cycles++;
        load = 1'b0; clear = 1'b0;
        checks++;
        if (data_out_a !== 8'h1F) begin
            errors++; $display("FAIL sweep_read15: got %h want 1f", data_out_a);
        end
        // third busy cycle: pointer at 2
        raddr_a = 4'd1; ren_b = 1'b1; raddr_b = 4'd2;
        tick();
        if (busy === 1'b1) busy_cycles++;
        checks++;
        if (data_out_a !== 8'h00) begin
            errors++; $display("FAIL sweep_cleared1: got %h want 00", data_out_a);
        end
        checks++;
        if (data_out_b !== 8'h00) begin
            errors++; $display("FAIL sweep_ptr_bypass2: got %h want 00", data_out_b);
        end
        ren_a = 1'b0; ren_b = 1'b0;
        for (int k = 0; k < 100 && busy === 1'b1; k++) begin
            tick();
            if (busy === 1'b1) busy_cycles++;
        end
        checks++;
        if (busy_cycles != 16 || busy !== 1'b0) begin
            errors++; $display("FAIL busy_cycles: got %0d (busy=%b) want 16", busy_cycles, busy);
        end
        ren_a = 1'b1; ren_b = 1'b1;
        for (int i = 0; i < 8; i++) begin
            raddr_a = 4'(i); raddr_b = 4'(i + 8);
            tick();
            checks++;
            if (data_out_a !== 8'h00 || data_out_b !== 8'h00) begin
                errors++;
                $display("FAIL cleared_%0d_%0d: got %h %h want 00 00", i, i + 8, data_out_a, data_out_b);
            end
        end
        idle_inputs();
    endtask

    task automatic test_reset_mid_sweep();
        write(4'd2, 8'h77);
        write(4'd10, 8'h99);
        clear = 1'b1;
        tick();
        clear = 1'b0;
        ren_a = 1'b1; raddr_a = 4'd10;
        repeat (4) tick();
        ren_a = 1'b0;
        checks++;
        if (busy !== 1'b1 || data_out_a !== 8'h99) begin
            errors++; $display("FAIL pre_reset: got busy=%b a=%h want 1 99", busy, data_out_a);
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        checks++;
        if (busy !== 1'b0 || data_out_a !== 8'h00) begin
            errors++; $display("FAIL mid_reset: got busy=%b a=%h want 0 00", busy, data_out_a);
        end
        ren_a = 1'b1; raddr_a = 4'd10;
        tick();
        checks++;
        if (data_out_a !== 8'h00 || busy !== 1'b0) begin
            errors++; $display("FAIL after_reset_r10: got %h busy=%b want 00 0", data_out_a, busy);
        end
        ren_a = 1'b0;
        write(4'd2, 8'h33);
        ren_b = 1'b1; raddr_b = 4'd2;
        tick();
        checks++;
        if (data_out_b !== 8'h33) begin
            errors++; $display("FAIL post_reset_rw2: got %h want 33", data_out_b);
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1'b0;
        idle_inputs();
        tick();
        test_reset();
        test_write_read();
        test_bypass();
        test_zero_reg();
        test_clear();
        test_reset_mid_sweep();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
